// File: rtl/reg_file_rd_stage.sv
// ---------------------------------------------------------------------------
// reg_file_rd_stage
//
// MIPS general-purpose register file with registered read ports. It feeds the
// ALU operands directly. There are two read ports, one write port from
// writeback, a write-first bypass and a hardwired $0. The stall input holds the
// operands and the flush input zeroes them, so the EX stage always sees stable
// values.
//
// Parameters:
//   DATA_W    register and data width in bits
//   ADDR_W    register index width (depth = 2**ADDR_W)
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-high reset; clears registers and outputs
//   r_reg1     read index A (rs)
//   r_reg2     read index B (rt)
//   reg_write  write enable from writeback
//   w_reg      write index
//   w_data     write data
//   stall      hold r_data1/r_data2
//   flush      zero r_data1/r_data2 (bubble into EX), overrides stall
//   r_data1    registered operand A (ALU oper1)
//   r_data2    registered operand B (ALU oper2)
// ---------------------------------------------------------------------------
module reg_file_rd_stage #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] r_reg1,
    input  logic [ADDR_W-1:0] r_reg2,
    input  logic              reg_write,
    input  logic [ADDR_W-1:0] w_reg,
    input  logic [DATA_W-1:0] w_data,
    input  logic              stall,
    input  logic              flush,
    output logic [DATA_W-1:0] r_data1,
    output logic [DATA_W-1:0] r_data2
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs [DEPTH];
    logic [DATA_W-1:0] rd_val1;
    logic [DATA_W-1:0] rd_val2;
    logic              write_en;

    // A write only lands when it targets a real register; $0 stays zero.
    assign write_en = reg_write && (w_reg != '0);

    // Next operand value for each port. Index 0 is checked first so a write
    // aimed at $0 can never leak through the bypass. Otherwise a same-cycle
    // write to the requested index wins over the stored copy (write-first).
    always_comb begin
        rd_val1 = regs[r_reg1];
        if (r_reg1 == '0) begin
            rd_val1 = '0;
        end else if (reg_write && (w_reg == r_reg1)) begin
            rd_val1 = w_data;
        end

        rd_val2 = regs[r_reg2];
        if (r_reg2 == '0) begin
            rd_val2 = '0;
        end else if (reg_write && (w_reg == r_reg2)) begin
            rd_val2 = w_data;
        end
    end

    // Register storage. Reset clears every entry and drops any write
    // presented in the same cycle. Writes ignore stall and flush, so
    // writeback keeps retiring while the front of the pipe is held.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (write_en) begin
            regs[w_reg] <= w_data;
        end
    end

    // Operand registers. Priority is reset, then flush, then stall. A write
    // that arrives while the outputs are held is picked up by the first
    // non-stalled edge because that edge re-reads the array (or the bypass).
    always_ff @(posedge clk) begin
        if (rst) begin
            r_data1 <= '0;
            r_data2 <= '0;
        end else if (flush) begin
            r_data1 <= '0;
            r_data2 <= '0;
        end else if (!stall) begin
            r_data1 <= rd_val1;
            r_data2 <= rd_val2;
        end
    end

endmodule

// File: doc/reg_file_rd_stage.md
Name: reg_file_rd_stage

Overview:
MIPS general-purpose register file with registered read ports. It sits directly upstream of the alu and drives the alu's oper1 and oper2 through r_data1 and r_data2. It has two read ports, one write port (from writeback), write-first bypass and a hardwired $0. A stall input holds the operands and a flush input zeroes them, so the EX stage always sees stable values.

Parameters:
DATA_W, 32, register and data width in bits.
ADDR_W, 5, register index width; depth = 2**ADDR_W = 32.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst  input  1  synchronous, active-high reset.
r_reg1  input  ADDR_W  read index A (rs).
r_reg2  input  ADDR_W  read index B (rt).
reg_write  input  1  write enable from writeback.
w_reg  input  ADDR_W  write index.
w_data  input  DATA_W  write data.
stall  input  1  hold the read outputs.
flush  input  1  zero the read outputs (bubble into EX).
r_data1  output  DATA_W  registered operand A; drives alu oper1.
r_data2  output  DATA_W  registered operand B; drives alu oper2.

Behaviour:
- Clocking and reset: one clock, clk. Reset is synchronous, active-high, on rst.
- Reset, when rst=1 at a rising edge:
  - all 32 registers go to 0;
  - r_data1 and r_data2 go to 0;
  - any write requested in the same cycle is dropped.
- Storage: 32 x DATA_W array. Register 0 is never written and always reads 0.
- Write path: at a rising edge with rst=0, reg_write=1 and w_reg!=0, regs[w_reg] <= w_data. Writes are independent of stall and flush.
- Read latency: one cycle. Indices presented in cycle N appear on r_data1/r_data2 after edge N+1. There is no combinational path from inputs to outputs.
- Read value per port p (computed at the edge):
  - 0 if r_regp==0;
  - else w_data if reg_write=1 and w_reg==r_regp (write-first bypass);
  - else regs[r_regp].
- Priority at each rising edge: rst > flush > stall > normal read.
  - flush=1 (rst=0): both outputs become 0 next cycle, whatever stall is.
  - stall=1 (rst=0, flush=0): both outputs hold their value.
  - A write to a register currently held under stall is not reflected until the first non-stalled edge, which then returns the new value.
- Both ports may read the same index in the same cycle. Each port applies the bypass independently.
- A write to index 0 is a no-op. A read of 0 in the same cycle returns 0, not w_data.
- Widths are exact. No sign extension or truncation; w_data is stored bit-for-bit.
- Reset mid-stall or mid-flush: reset wins, and outputs are 0 on the next cycle.
- Contents persist indefinitely between writes. Only rst clears them.

Test Plan:
1. Reset, then a write, then a read:
   - Stimulus: assert rst for 2 cycles, then write reg 5 = 0x00000007. Next cycle read r_reg1=5, r_reg2=0.
   - Required response: one cycle later r_data1=0x00000007, r_data2=0x00000000. Both outputs are 0 during and right after reset.
2. Bypass:
   - Stimulus: in the same cycle drive reg_write=1, w_reg=3, w_data=0x00000003, r_reg1=3, r_reg2=3.
   - Required response: next cycle r_data1=r_data2=0x00000003. The old value is not visible.
3. $0 protection:
   - Stimulus: write reg 0 = 0xFFFFFFFF with r_reg1=0 in the same cycle, then read reg 0 again.
   - Required response: r_data1=0 both times.
4. Stall and flush:
   - Stimulus: load reg 1=1 and reg 2=2, read them, then stall for 3 cycles while writing reg 1=9. Release the stall, then flush with stall=1.
   - Required response: outputs hold 1/2 during the stall. They become 9/2 on the first non-stalled edge. They become 0/0 on the flush edge (flush beats stall).
5. Full sweep:
   - Stimulus: write reg i = i*0x01010101 for i=1..31, then read all pairs (i, 31-i).
   - Required response: every value matches, and index 0 reads 0.
6. Reset mid-operation:
   - Stimulus: with reg 4=0x12345678 and reads active, assert rst for 1 cycle together with reg_write=1, w_reg=4, w_data=0xAAAAAAAA.
   - Required response: outputs are 0 next cycle, and a later read of reg 4 returns 0 (the write is dropped).
